// File: rtl/logic_gates_pkg.sv
// Shared types and sizes for the logic_gates sweep checker.
package logic_gates_pkg;

  // Checker sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 32;
  localparam int SW_WIDTH    = 5;
  localparam int ERR_WIDTH   = 6;

  // Final switch pattern of a sweep
  localparam logic [SW_WIDTH-1:0] LAST_VECTOR = SW_WIDTH'(NUM_VECTORS - 1);

endpackage

// File: rtl/logic_gates_sweep_checker_settle_timer.sv
// settle_timer: loadable down-counter that flags when a switch pattern has
// been held for SETTLE_CYCLES cycles. Loading sets the count to
// SETTLE_CYCLES-1, so expired is high in the SETTLE_CYCLES-th cycle after load.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CNT_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LOAD_VALUE = CNT_WIDTH'(SETTLE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_reg;

  // Reload on request, otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VALUE;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/logic_gates_sweep_checker.sv
// logic_gates_sweep_checker: drives all 32 switch patterns to the logic_gates
// UUT, samples its result after a settle interval and compares it with the
// EXPECTED truth table. Optional macro SWEEP_CAPTURE_EN builds a register
// holding the observed truth table; without it, captured is tied to zero.
module logic_gates_sweep_checker
  import logic_gates_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] EXPECTED      = 32'h8000_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   result_in,
  output logic [SW_WIDTH-1:0]    sw_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [SW_WIDTH-1:0]    first_fail,
  output logic [NUM_VECTORS-1:0] captured
);

  state_t               state_reg;
  state_t               state_next;
  logic                 accept;
  logic                 load;
  logic                 sample;
  logic                 expired;
  logic                 mismatch;
  logic [SW_WIDTH-1:0]  sw_reg;
  logic [ERR_WIDTH-1:0] err_reg;
  logic [SW_WIDTH-1:0]  first_fail_reg;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    load       = 1'b0;
    sample     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = APPLY;
          accept     = 1'b1;
          load       = 1'b1;
        end
      end
      APPLY: begin
        if (expired) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        sample = 1'b1;
        if (sw_reg == LAST_VECTOR) begin
          state_next = DONE;
        end else begin
          state_next = APPLY;
          load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mismatch = (result_in != EXPECTED[sw_reg]);

  // Switch vector, error count and first failing vector
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_reg         <= '0;
      err_reg        <= '0;
      first_fail_reg <= '0;
    end else if (accept) begin
      sw_reg         <= '0;
      err_reg        <= '0;
      first_fail_reg <= '0;
    end else if (sample) begin
      if (mismatch) begin
        err_reg <= err_reg + 1'b1;
        if (err_reg == '0) begin
          first_fail_reg <= sw_reg;
        end
      end
      // Hold at the last vector so sw_out never wraps into DONE
      if (sw_reg != LAST_VECTOR) begin
        sw_reg <= sw_reg + 1'b1;
      end
    end
  end

`ifdef SWEEP_CAPTURE_EN
  logic [NUM_VECTORS-1:0] captured_reg;

  // Record the observed result for each vector
  always_ff @(posedge clk) begin
    if (rst) begin
      captured_reg <= '0;
    end else if (accept) begin
      captured_reg <= '0;
    end else if (sample) begin
      captured_reg[sw_reg] <= result_in;
    end
  end

  assign captured = captured_reg;
`else
  assign captured = '0;
`endif

  assign sw_out     = sw_reg;
  assign busy       = (state_reg == APPLY) || (state_reg == SAMPLE);
  assign done       = (state_reg == DONE);
  assign pass       = done && (err_reg == '0);
  assign err_count  = err_reg;
  assign first_fail = first_fail_reg;

endmodule
